// File: rtl/branch_sequencer.sv
// Branch resolution sequencer.
// Resolves one beq/bne branch per request using a three-state FSM:
//   IDLE    -> wait for Start, then snapshot the operands
//   COMPARE -> register the outcome and the taken-branch target
//   UPDATE  -> select the next PC and register the PC-load strobe
// The PC-load strobe and the completion pulse are registered outputs
// produced by the UPDATE state, so with Start sampled at edge n they are
// high for exactly the cycle between edges n+2 and n+3. A reset that
// lands anywhere inside COMPARE or UPDATE therefore suppresses the pulse.
module branch_sequencer #(
    parameter int WIDTH = 16,
    parameter int OFFW  = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             EorNE,
    input  logic [WIDTH-1:0] RegA,
    input  logic [WIDTH-1:0] RegB,
    input  logic [WIDTH-1:0] PC,
    input  logic [OFFW-1:0]  Offset,
    output logic             Busy,
    output logic             PCWrite,
    output logic [WIDTH-1:0] NewPC,
    output logic             Taken,
    output logic             Done
);

    // FSM encoding; the fourth code is unreachable and recovers to IDLE.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_UPDATE  = 2'd2;

    // Increment used for the fall-through (not-taken) address.
    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    // Sign-extend a word offset to the datapath width.
    function automatic logic [WIDTH-1:0] sign_extend(input logic [OFFW-1:0] off);
        sign_extend = WIDTH'($signed(off));
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;

    // Operand snapshot taken at the Start edge; immune to later input changes.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] pc_r;
    logic [OFFW-1:0]  off_r;
    logic             eorne_r;

    // Results of the COMPARE state.
    logic             taken_r;
    logic [WIDTH-1:0] target_r;

    // Registered outputs of the UPDATE state.
    logic             pcwrite_r;
    logic             done_r;
    logic [WIDTH-1:0] newpc_r;

    // Combinational helpers.
    logic             capture_s;
    logic             eq_s;
    logic             taken_next_s;
    logic [WIDTH-1:0] target_next_s;
    logic [WIDTH-1:0] seq_pc_s;
    logic [WIDTH-1:0] newpc_next_s;

    assign capture_s     = (state_r == S_IDLE) && Start;
    assign eq_s          = (a_r == b_r);
    assign taken_next_s  = eorne_r ? eq_s : ~eq_s;
    assign target_next_s = pc_r + sign_extend(off_r);
    assign seq_pc_s      = pc_r + PC_STEP;
    assign newpc_next_s  = taken_r ? target_r : seq_pc_s;

    // Next-state decode; Start is only honoured in IDLE so it never queues.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    state_next_s = S_COMPARE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_COMPARE: state_next_s = S_UPDATE;
            S_UPDATE:  state_next_s = S_IDLE;
            default:   state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on an accepted Start; otherwise the snapshot holds.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            pc_r    <= {WIDTH{1'b0}};
            off_r   <= {OFFW{1'b0}};
            eorne_r <= 1'b0;
        end else if (capture_s) begin
            a_r     <= RegA;
            b_r     <= RegB;
            pc_r    <= PC;
            off_r   <= Offset;
            eorne_r <= EorNE;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            pc_r    <= pc_r;
            off_r   <= off_r;
            eorne_r <= eorne_r;
        end
    end

    // Branch outcome and target, registered while in COMPARE; Taken then
    // holds until the next branch reaches COMPARE.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            taken_r  <= 1'b0;
            target_r <= {WIDTH{1'b0}};
        end else if (state_r == S_COMPARE) begin
            taken_r  <= taken_next_s;
            target_r <= target_next_s;
        end else begin
            taken_r  <= taken_r;
            target_r <= target_r;
        end
    end

    // PC-load strobe, completion pulse and next PC, registered out of UPDATE.
    // NewPC keeps its last value between branches.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pcwrite_r <= 1'b0;
            done_r    <= 1'b0;
            newpc_r   <= {WIDTH{1'b0}};
        end else if (state_r == S_UPDATE) begin
            pcwrite_r <= 1'b1;
            done_r    <= 1'b1;
            newpc_r   <= newpc_next_s;
        end else begin
            pcwrite_r <= 1'b0;
            done_r    <= 1'b0;
            newpc_r   <= newpc_r;
        end
    end

    assign Busy    = (state_r != S_IDLE);
    assign PCWrite = pcwrite_r;
    assign Done    = done_r;
    assign NewPC   = newpc_r;
    assign Taken   = taken_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_branch_sequencer;

    logic        CLK;
    logic        Reset_n;
    logic        Start;
    logic        EorNE;
    logic [15:0] RegA;
    logic [15:0] RegB;
    logic [15:0] PC;
    logic [7:0]  Offset;
    logic        Busy;
    logic        PCWrite;
    logic [15:0] NewPC;
    logic        Taken;
    logic        Done;

    int errors;
    int checks;

    branch_sequencer #(.WIDTH(16), .OFFW(8)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .Start   (Start),
        .EorNE   (EorNE),
        .RegA    (RegA),
        .RegB    (RegB),
        .PC      (PC),
        .Offset  (Offset),
        .Busy    (Busy),
        .PCWrite (PCWrite),
        .NewPC   (NewPC),
        .Taken   (Taken),
        .Done    (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called just after a falling edge with the FSM idle: present one branch,
    // let the next rising edge (edge n) capture it, then drop Start and
    // scramble every operand input. Returns just after edge n.
    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] pc, input logic [7:0] off,
                          input logic eorne);
        RegA   = a;
        RegB   = b;
        PC     = pc;
        Offset = off;
        EorNE  = eorne;
        Start  = 1'b1;
        @(negedge CLK);
        Start  = 1'b0;
        RegA   = ~a;
        RegB   = b + 16'h0001;
        PC     = pc + 16'h0040;
        Offset = ~off;
        EorNE  = ~eorne;
    endtask

    // Launch a branch and check the pulse two edges after capture.
    task automatic run_branch(input string name,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] pc, input logic [7:0] off,
                              input logic eorne,
                              input logic exp_taken, input logic [15:0] exp_pc);
        launch(a, b, pc, off, eorne);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (PCWrite !== 1'b1 || Done !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse: PCWrite=%b Done=%b required 1 1", name, PCWrite, Done);
        end
        checks++;
        if (Taken !== exp_taken) begin
            errors++;
            $display("FAIL %s taken: got %b required %b", name, Taken, exp_taken);
        end
        checks++;
        if (NewPC !== exp_pc) begin
            errors++;
            $display("FAIL %s newpc: got %h required %h", name, NewPC, exp_pc);
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b1;
        Start   = 1'b0;
        EorNE   = 1'b0;
        RegA    = 16'h0000;
        RegB    = 16'h0000;
        PC      = 16'h0000;
        Offset  = 8'h00;
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || PCWrite !== 1'b0 || Done !== 1'b0 || Taken !== 1'b0 || NewPC !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: Busy=%b PCWrite=%b Done=%b Taken=%b NewPC=%h required 0 0 0 0 0000",
                     Busy, PCWrite, Done, Taken, NewPC);
        end
        Start = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_start: Busy=%b required 0", Busy);
        end
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: Busy=%b PCWrite=%b required 0 0", Busy, PCWrite);
        end
    endtask

    // beq taken with full cycle-by-cycle latency check.
    task automatic test_beq_taken;
        launch(16'h1234, 16'h1234, 16'h0010, 8'h05, 1'b1);
        checks++;
        if (Busy !== 1'b1 || PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL lat_compare: Busy=%b PCWrite=%b required 1 0", Busy, PCWrite);
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b1 || PCWrite !== 1'b0 || Done !== 1'b0 || Taken !== 1'b1) begin
            errors++;
            $display("FAIL lat_update: Busy=%b PCWrite=%b Done=%b Taken=%b required 1 0 0 1",
                     Busy, PCWrite, Done, Taken);
        end
        @(negedge CLK);
        checks++;
        if (PCWrite !== 1'b1 || Done !== 1'b1 || NewPC !== 16'h0015 || Taken !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: PCWrite=%b Done=%b NewPC=%h Taken=%b required 1 1 0015 1",
                     PCWrite, Done, NewPC, Taken);
        end
        @(negedge CLK);
        checks++;
        if (PCWrite !== 1'b0 || Done !== 1'b0 || NewPC !== 16'h0015 || Taken !== 1'b1) begin
            errors++;
            $display("FAIL pulse_end_hold: PCWrite=%b Done=%b NewPC=%h Taken=%b required 0 0 0015 1",
                     PCWrite, Done, NewPC, Taken);
        end
    endtask

    task automatic test_not_taken_bne;
        run_branch("beq_not_taken", 16'h0003, 16'h0004, 16'h0010, 8'hFE, 1'b1, 1'b0, 16'h0011);
        run_branch("bne_taken",     16'h0003, 16'h0004, 16'h0010, 8'hFE, 1'b0, 1'b1, 16'h000E);
        run_branch("bne_not_taken", 16'h0009, 16'h0009, 16'h0200, 8'h10, 1'b0, 1'b0, 16'h0201);
    endtask

    task automatic test_wrap;
        run_branch("wrap_seq",    16'h0001, 16'h0002, 16'hFFFF, 8'h05, 1'b1, 1'b0, 16'h0000);
        run_branch("wrap_target", 16'h0005, 16'h0005, 16'h0000, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
    endtask

    // Start held six cycles while RegB toggles: two branches, three cycles apart.
    task automatic test_back_to_back;
        int pulses;
        int first_c;
        int second_c;
        logic [15:0] pc1;
        logic [15:0] pc2;
        logic t1;
        logic t2;
        pulses = 0; first_c = 0; second_c = 0;
        pc1 = 16'h0000; pc2 = 16'h0000; t1 = 1'b0; t2 = 1'b0;
        RegA = 16'h0007; RegB = 16'h0007; EorNE = 1'b1;
        PC = 16'h0100; Offset = 8'h04; Start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (PCWrite === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_c = c; pc1 = NewPC; t1 = Taken;
                end else if (pulses == 2) begin
                    second_c = c; pc2 = NewPC; t2 = Taken;
                end
            end
            if (c < 6) RegB = (RegB == 16'h0007) ? 16'h0008 : 16'h0007;
            else Start = 1'b0;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses required 2", pulses);
        end
        checks++;
        if (first_c != 3 || second_c != 6) begin
            errors++;
            $display("FAIL b2b_timing: pulses at cycle %0d and %0d required 3 and 6", first_c, second_c);
        end
        checks++;
        if (pc1 !== 16'h0104 || t1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: NewPC=%h Taken=%b required 0104 1", pc1, t1);
        end
        checks++;
        if (pc2 !== 16'h0101 || t2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: NewPC=%h Taken=%b required 0101 0", pc2, t2);
        end
    endtask

    // Reset between edges in COMPARE, then in UPDATE; both abort silently.
    task automatic test_reset_midop;
        int pulses;
        launch(16'h0042, 16'h0042, 16'h0300, 8'h08, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || PCWrite !== 1'b0 || NewPC !== 16'h0000 || Taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_compare: Busy=%b PCWrite=%b NewPC=%h Taken=%b required 0 0 0000 0",
                     Busy, PCWrite, NewPC, Taken);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (PCWrite !== 1'b0 || Busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_compare_abort: %0d active cycles required 0", pulses);
        end
        run_branch("after_reset", 16'h0001, 16'h0001, 16'h0400, 8'h02, 1'b1, 1'b1, 16'h0402);

        launch(16'h0011, 16'h0022, 16'h0500, 8'h01, 1'b1);
        @(negedge CLK);
        #2 Reset_n = 1'b0;
        @(negedge CLK);
        checks++;
        if (PCWrite !== 1'b0 || Done !== 1'b0 || NewPC !== 16'h0000 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_update: PCWrite=%b Done=%b NewPC=%h Busy=%b required 0 0 0000 0",
                     PCWrite, Done, NewPC, Busy);
        end
        Reset_n = 1'b1;
        @(negedge CLK);
    endtask

    // RegA, RegB over 0..9, both branch types.
    task automatic test_sweep;
        logic exp_t;
        logic [15:0] exp_pc;
        for (int e = 0; e < 2; e++) begin
            for (int a = 0; a < 10; a++) begin
                for (int b = 0; b < 10; b++) begin
                    exp_t  = (e == 1) ? (a == b) : (a != b);
                    exp_pc = exp_t ? 16'h0023 : 16'h0021;
                    launch(16'(a), 16'(b), 16'h0020, 8'h03, e[0]);
                    @(negedge CLK);
                    @(negedge CLK);
                    checks++;
                    if (PCWrite !== 1'b1 || Taken !== exp_t || NewPC !== exp_pc) begin
                        errors++;
                        $display("FAIL sweep a=%0d b=%0d eorne=%0d: PCWrite=%b Taken=%b NewPC=%h required 1 %b %h",
                                 a, b, e, PCWrite, Taken, NewPC, exp_t, exp_pc);
                    end
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_beq_taken();
        test_not_taken_bne();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
